// File: rtl/regwrite_scheduler_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Forwarding build option: REGWRITE_SCHED_FORWARD_EN.
package regwrite_scheduler_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int NREG_DEFAULT = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

    localparam logic WB_ALU  = 1'b0;
    localparam logic WB_LOAD = 1'b1;

    typedef enum logic {
        PREF_ALU  = WB_ALU,
        PREF_LOAD = WB_LOAD
    } rr_state_t;

endpackage

// File: rtl/regwrite_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer names the preferred port and
// flips to the other port after every grant.
module rr_arbiter2
    import regwrite_scheduler_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

    rr_state_t rr_reg;
    rr_state_t rr_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_reg <= PREF_ALU;
        end else begin
            rr_reg <= rr_next;
        end
    end

    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        rr_next = rr_reg;
        if (req0 && (!req1 || rr_reg == PREF_ALU)) begin
            grant0  = 1'b1;
            rr_next = PREF_LOAD;
        end else if (req1) begin
            grant1  = 1'b1;
            rr_next = PREF_ALU;
        end
    end

endmodule

// File: rtl/regwrite_scheduler.sv
// Arbitrates ALU/load writebacks onto the single register-file write port and
// tracks pending writes per register. Optional bypass: REGWRITE_SCHED_FORWARD_EN.
module regwrite_scheduler
    import regwrite_scheduler_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int CNTW = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        reserve_valid,
    input  logic [4:0]  reserve_reg,
    output logic        reserve_ready,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_reg,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_reg,
    input  logic [31:0] req1_data,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    input  logic [4:0]  readRegister1,
    input  logic [4:0]  readRegister2,
    output logic        stall,
    output logic        fwd1_valid,
    output logic        fwd2_valid,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data
);

    localparam logic [CNTW-1:0] PEND_MAX = '1;
    localparam logic [CNTW-1:0] PEND_ONE = CNTW'(1);

    logic grant0;
    logic grant1;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Write stage
    logic        hs_any;
    reg_idx_t    wb_reg_next;
    logic [31:0] wb_data_next;
    logic        regwrite_reg;
    reg_idx_t    write_reg_reg;
    logic [31:0] write_data_reg;

    assign hs_any = grant0 | grant1;

    always_comb begin
        wb_reg_next  = req0_reg;
        wb_data_next = req0_data;
        if (grant1) begin
            wb_reg_next  = req1_reg;
            wb_data_next = req1_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regwrite_reg   <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
        end else begin
            regwrite_reg <= hs_any && (wb_reg_next != ZERO_REG);
            if (hs_any) begin
                write_reg_reg  <= wb_reg_next;
                write_data_reg <= wb_data_next;
            end
        end
    end

    assign regWrite      = regwrite_reg;
    assign writeRegister = write_reg_reg;
    assign writeData     = write_data_reg;

    // Pending-write scoreboard
    logic [NREG-1:0][CNTW-1:0] pend;
    logic                      reserve_fire;

    // A commit to the same register this edge frees a slot, so accept even at max.
    assign reserve_ready = (reserve_reg == ZERO_REG)
                        || (pend[reserve_reg] != PEND_MAX)
                        || (regwrite_reg && write_reg_reg == reserve_reg);
    assign reserve_fire  = reserve_valid && reserve_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend[gi] = '0;
            end else begin : g_cnt
                logic            inc;
                logic            dec;
                logic [CNTW-1:0] cnt_reg;
                logic [CNTW-1:0] cnt_next;

                assign inc = reserve_fire && (reserve_reg == reg_idx_t'(gi));
                assign dec = regwrite_reg && (write_reg_reg == reg_idx_t'(gi));

                always_comb begin
                    cnt_next = cnt_reg;
                    if (inc && !dec) begin
                        cnt_next = cnt_reg + PEND_ONE;
                    end else if (dec && !inc && cnt_reg != '0) begin
                        cnt_next = cnt_reg - PEND_ONE;
                    end
                end

                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                assign pend[gi] = cnt_reg;
            end
        end
    endgenerate

    logic [CNTW-1:0] pend1;
    logic [CNTW-1:0] pend2;
    logic            op1_stall;
    logic            op2_stall;

    assign pend1 = pend[readRegister1];
    assign pend2 = pend[readRegister2];

`ifdef REGWRITE_SCHED_FORWARD_EN
    logic fwd1_hit;
    logic fwd2_hit;

    assign fwd1_hit = regwrite_reg && (write_reg_reg == readRegister1) && (readRegister1 != ZERO_REG);
    assign fwd2_hit = regwrite_reg && (write_reg_reg == readRegister2) && (readRegister2 != ZERO_REG);

    // Only the oldest outstanding write can be bypassed; younger ones still stall.
    assign op1_stall = (pend1 != '0) && ((pend1 > PEND_ONE) || !fwd1_hit);
    assign op2_stall = (pend2 != '0) && ((pend2 > PEND_ONE) || !fwd2_hit);

    assign fwd1_valid = fwd1_hit;
    assign fwd2_valid = fwd2_hit;
    assign fwd1_data  = write_data_reg;
    assign fwd2_data  = write_data_reg;
`else
    assign op1_stall = (pend1 != '0);
    assign op2_stall = (pend2 != '0);

    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif

    assign stall = op1_stall || op2_stall;

endmodule
